// File: rtl/led_panel_framebuffer.sv
// ---------------------------------------------------------------------------
// led_panel_framebuffer
//
// Double-buffered 3-bit RGB frame memory for a COLUMNS x (2*ROW_PAIRS) LED
// panel, placed directly upstream of the panel scan driver.
//
// The pixel writer fills the back bank.  The scan driver reads the front bank
// and gets the upper-half and lower-half pixels of a row pair together.  A
// requested front/back exchange waits for the scan driver's frame boundary,
// so a frame is never displayed torn.
//
// Ports
//   clock_i          system clock, all logic on posedge
//   reset_i          synchronous active-high reset (memory contents kept)
//   wr_valid_i       pixel write request
//   wr_ready_o       write accepted when wr_valid_i && wr_ready_o at posedge
//   wr_x_i           write column
//   wr_y_i           write row; MSB selects the upper/lower half array
//   wr_rgb_i         write colour {R,G,B}
//   clear_i          pulse: zero the whole back bank
//   busy_o           high while a clear is running
//   swap_req_i       pulse: request front/back exchange
//   swap_pending_o   swap requested but not yet executed
//   frame_end_i      pulse from scan driver after its last scan address
//   swap_done_o      one-cycle pulse in the cycle after the swap executes
//   front_bank_o     bank currently displayed
//   rd_en_i          read request
//   rd_address_i     scan address (row pair)
//   rd_column_i      column
//   rd_rgb_0_o       pixel at row rd_address_i
//   rd_rgb_1_o       pixel at row rd_address_i + ROW_PAIRS
//   rd_valid_o       rd_rgb_*_o valid (one cycle after rd_en_i)
// ---------------------------------------------------------------------------
module led_panel_framebuffer #(
    parameter int COLUMNS   = 32,
    parameter int ROW_PAIRS = 8
) (
    input  logic                             clock_i,
    input  logic                             reset_i,

    input  logic                             wr_valid_i,
    output logic                             wr_ready_o,
    input  logic [$clog2(COLUMNS)-1:0]       wr_x_i,
    input  logic [$clog2(ROW_PAIRS):0]       wr_y_i,
    input  logic [2:0]                       wr_rgb_i,

    input  logic                             clear_i,
    output logic                             busy_o,

    input  logic                             swap_req_i,
    output logic                             swap_pending_o,
    input  logic                             frame_end_i,
    output logic                             swap_done_o,
    output logic                             front_bank_o,

    input  logic                             rd_en_i,
    input  logic [$clog2(ROW_PAIRS)-1:0]     rd_address_i,
    input  logic [$clog2(COLUMNS)-1:0]       rd_column_i,
    output logic [2:0]                       rd_rgb_0_o,
    output logic [2:0]                       rd_rgb_1_o,
    output logic                             rd_valid_o
);

    localparam int COL_W  = $clog2(COLUMNS);
    localparam int ADDR_W = $clog2(ROW_PAIRS);
    localparam int CNT_W  = ADDR_W + COL_W;
    localparam int MEM_AW = 1 + CNT_W;
    localparam int DEPTH  = 2 * ROW_PAIRS * COLUMNS;

    localparam logic [CNT_W-1:0] CLR_LAST = '1;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_t;

    // Two half-panel arrays, indexed {bank, row[ADDR_W-1:0], col}.
    logic [2:0] upper_mem [0:DEPTH-1];
    logic [2:0] lower_mem [0:DEPTH-1];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               front_q, front_d;
    logic               pending_q, pending_d;
    logic               swap_done_q, swap_done_d;
    logic               rd_valid_q;
    logic [2:0]         rd_rgb_0_q;
    logic [2:0]         rd_rgb_1_q;

    logic               up_we;
    logic               lo_we;
    logic [MEM_AW-1:0]  we_addr;
    logic [2:0]         we_data;
    logic               swap_exec;
    logic [MEM_AW-1:0]  rd_index;

    // A frame boundary seen while clearing is dropped on purpose: swapping
    // then would display a half-cleared bank.
    assign swap_exec = pending_q && frame_end_i && (state_q != CLEARING);

    // Reads always use the bank displayed before this edge, so a read issued
    // together with the swapping frame_end_i still sees the old frame.
    assign rd_index = {front_q, rd_address_i, rd_column_i};

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        up_we      = 1'b0;
        lo_we      = 1'b0;
        we_addr    = '0;
        we_data    = '0;
        wr_ready_o = 1'b0;
        busy_o     = 1'b0;

        case (state_q)
            IDLE: begin
                wr_ready_o = 1'b1;
                if (wr_valid_i) begin
                    we_addr = {~front_q, wr_y_i[ADDR_W-1:0], wr_x_i};
                    we_data = wr_rgb_i;
                    if (wr_y_i[ADDR_W]) begin
                        lo_we = 1'b1;
                    end else begin
                        up_we = 1'b1;
                    end
                end
                if (clear_i) begin
                    state_d   = CLEARING;
                    clr_cnt_d = '0;
                end
            end

            CLEARING: begin
                busy_o    = 1'b1;
                up_we     = 1'b1;
                lo_we     = 1'b1;
                we_addr   = {~front_q, clr_cnt_q};
                we_data   = 3'b000;
                // Counter wraps to zero after the last location, ready for
                // the next clear.
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        front_d     = front_q ^ swap_exec;
        swap_done_d = swap_exec;
        pending_d   = pending_q;
        // Execution wins over a coincident request; the merged request is
        // satisfied by this swap.
        if (swap_exec) begin
            pending_d = 1'b0;
        end else if (swap_req_i) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            front_q     <= 1'b0;
            pending_q   <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            front_q     <= front_d;
            pending_q   <= pending_d;
            swap_done_q <= swap_done_d;
        end
    end

    // Storage is never reset; an interrupted clear leaves memory as it was.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            if (up_we) begin
                upper_mem[we_addr] <= we_data;
            end
            if (lo_we) begin
                lower_mem[we_addr] <= we_data;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_valid_q <= 1'b0;
            rd_rgb_0_q <= 3'b000;
            rd_rgb_1_q <= 3'b000;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_rgb_0_q <= upper_mem[rd_index];
                rd_rgb_1_q <= lower_mem[rd_index];
            end
        end
    end

    assign swap_pending_o = pending_q;
    assign swap_done_o    = swap_done_q;
    assign front_bank_o   = front_q;
    assign rd_valid_o     = rd_valid_q;
    assign rd_rgb_0_o     = rd_rgb_0_q;
    assign rd_rgb_1_o     = rd_rgb_1_q;

endmodule

// File: tb/tb_led_panel_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_led_panel_framebuffer
//
// Directed bench for led_panel_framebuffer.  Expected read data is pushed to
// a scoreboard queue when a read is issued and popped when the DUT answers.
// ---------------------------------------------------------------------------
module tb_led_panel_framebuffer;

    typedef struct packed {
        logic [2:0] rgb0;
        logic [2:0] rgb1;
    } rdExp_t;

    logic       clock;
    logic       reset;
    logic       wrValid;
    logic       wrReady;
    logic [4:0] wrX;
    logic [3:0] wrY;
    logic [2:0] wrRgb;
    logic       clear;
    logic       busy;
    logic       swapReq;
    logic       swapPending;
    logic       frameEnd;
    logic       swapDone;
    logic       frontBank;
    logic       rdEn;
    logic [2:0] rdAddress;
    logic [4:0] rdColumn;
    logic [2:0] rdRgb0;
    logic [2:0] rdRgb1;
    logic       rdValid;

    rdExp_t     sbQ[$];
    int         total;
    int         bad;
    logic [2:0] lastRgb0;
    logic [2:0] lastRgb1;
    logic       expFront;
    int         busyCycles;
    logic       leak;

    led_panel_framebuffer #(
        .COLUMNS   (32),
        .ROW_PAIRS (8)
    ) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .wr_valid_i     (wrValid),
        .wr_ready_o     (wrReady),
        .wr_x_i         (wrX),
        .wr_y_i         (wrY),
        .wr_rgb_i       (wrRgb),
        .clear_i        (clear),
        .busy_o         (busy),
        .swap_req_i     (swapReq),
        .swap_pending_o (swapPending),
        .frame_end_i    (frameEnd),
        .swap_done_o    (swapDone),
        .front_bank_o   (frontBank),
        .rd_en_i        (rdEn),
        .rd_address_i   (rdAddress),
        .rd_column_i    (rdColumn),
        .rd_rgb_0_o     (rdRgb0),
        .rd_rgb_1_o     (rdRgb1),
        .rd_valid_o     (rdValid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted write: wrReady must be high while wrValid is presented.
    task automatic applyStimulus(input logic [4:0] x, input logic [3:0] y, input logic [2:0] rgb);
        wrValid = 1'b1;
        wrX     = x;
        wrY     = y;
        wrRgb   = rgb;
        checkOutput("wr_ready", 32'(wrReady), 32'd1);
        tick();
        wrValid = 1'b0;
    endtask

    task automatic collectRead(input string tag);
        rdExp_t e;
        if (sbQ.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbQ.pop_front();
            checkOutput(tag, 32'({rdValid, rdRgb0, rdRgb1}), 32'({1'b1, e.rgb0, e.rgb1}));
            lastRgb0 = e.rgb0;
            lastRgb1 = e.rgb1;
        end
    endtask

    // Issues a read and leaves rdEn high so consecutive calls run back to back.
    task automatic issueRead(input string tag, input logic [2:0] addr, input logic [4:0] col,
                             input logic [2:0] e0, input logic [2:0] e1);
        rdEn      = 1'b1;
        rdAddress = addr;
        rdColumn  = col;
        sbQ.push_back('{rgb0: e0, rgb1: e1});
        tick();
        collectRead(tag);
    endtask

    task automatic endRead();
        rdEn = 1'b0;
        tick();
        checkOutput("rd_idle_hold", 32'({rdValid, rdRgb0, rdRgb1}), 32'({1'b0, lastRgb0, lastRgb1}));
    endtask

    task automatic waitNotBusy(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            n++;
            tick();
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    task automatic doSwap(input string tag);
        swapReq = 1'b1;
        tick();
        swapReq  = 1'b0;
        frameEnd = 1'b1;
        tick();
        frameEnd = 1'b0;
        expFront = ~expFront;
        checkOutput({tag, "_front"}, 32'(frontBank), 32'(expFront));
        checkOutput({tag, "_done"}, 32'(swapDone), 32'd1);
        tick();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        lastRgb0  = 3'd0;
        lastRgb1  = 3'd0;
        expFront  = 1'b0;
        reset     = 1'b1;
        wrValid   = 1'b0;
        wrX       = '0;
        wrY       = '0;
        wrRgb     = '0;
        clear     = 1'b0;
        swapReq   = 1'b0;
        frameEnd  = 1'b0;
        rdEn      = 1'b0;
        rdAddress = '0;
        rdColumn  = '0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_front", 32'(frontBank), 32'd0);
        checkOutput("rst_ready", 32'(wrReady), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_pending", 32'(swapPending), 32'd0);
        checkOutput("rst_done", 32'(swapDone), 32'd0);
        checkOutput("rst_rd", 32'({rdValid, rdRgb0, rdRgb1}), 32'd0);
        reset = 1'b0;
        tick();

        // Write, swap, read back through the new front bank
        applyStimulus(5'd5, 4'd3, 3'd5);
        applyStimulus(5'd5, 4'd11, 3'd2);
        swapReq = 1'b1;
        tick();
        swapReq = 1'b0;
        checkOutput("ws_pending", 32'(swapPending), 32'd1);
        frameEnd = 1'b1;
        tick();
        frameEnd = 1'b0;
        expFront = 1'b1;
        checkOutput("ws_front", 32'(frontBank), 32'd1);
        checkOutput("ws_done", 32'(swapDone), 32'd1);
        checkOutput("ws_pending_clr", 32'(swapPending), 32'd0);
        tick();
        checkOutput("ws_done_pulse", 32'(swapDone), 32'd0);
        issueRead("ws_read", 3'd3, 5'd5, 3'd5, 3'd2);
        endRead();

        // Deferred swap: back bank written, no FRAME_END for 100 cycles
        applyStimulus(5'd7, 4'd2, 3'd3);
        applyStimulus(5'd7, 4'd10, 3'd6);
        applyStimulus(5'd1, 4'd8, 3'd1);
        swapReq = 1'b1;
        tick();
        swapReq = 1'b0;
        repeat (100) tick();
        checkOutput("def_pending", 32'(swapPending), 32'd1);
        checkOutput("def_front", 32'(frontBank), 32'd1);
        issueRead("def_old_read", 3'd3, 5'd5, 3'd5, 3'd2);
        rdEn = 1'b0;
        tick();

        // FRAME_END with a coincident write and read: write hits the
        // outgoing back bank, read still sees the old front bank.
        frameEnd = 1'b1;
        wrValid  = 1'b1;
        wrX      = 5'd1;
        wrY      = 4'd0;
        wrRgb    = 3'd4;
        issueRead("swap_edge_read", 3'd3, 5'd5, 3'd5, 3'd2);
        frameEnd = 1'b0;
        wrValid  = 1'b0;
        expFront = 1'b0;
        checkOutput("def_front_new", 32'(frontBank), 32'd0);
        checkOutput("def_done", 32'(swapDone), 32'd1);
        issueRead("def_new_read_a", 3'd2, 5'd7, 3'd3, 3'd6);
        issueRead("def_new_read_b", 3'd0, 5'd1, 3'd4, 3'd1);
        endRead();

        // SWAP_REQ together with FRAME_END waits for the next FRAME_END
        swapReq  = 1'b1;
        frameEnd = 1'b1;
        tick();
        swapReq  = 1'b0;
        frameEnd = 1'b0;
        checkOutput("same_front", 32'(frontBank), 32'(expFront));
        checkOutput("same_pending", 32'(swapPending), 32'd1);
        frameEnd = 1'b1;
        tick();
        frameEnd = 1'b0;
        expFront = ~expFront;
        checkOutput("same_front_next", 32'(frontBank), 32'(expFront));
        tick();

        // Clear: fill back bank with 7, clear while holding a write at (0,0)
        wrValid = 1'b1;
        wrRgb   = 3'd7;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 32; x++) begin
                wrX = 5'(x);
                wrY = 4'(y);
                tick();
            end
        end
        wrX   = 5'd0;
        wrY   = 4'd0;
        clear = 1'b1;
        tick();
        clear      = 1'b0;
        busyCycles = 0;
        leak       = 1'b0;
        while (busy && busyCycles < 400) begin
            if (wrReady) leak = 1'b1;
            busyCycles++;
            tick();
        end
        wrValid = 1'b0;
        checkOutput("clr_cycles", 32'(busyCycles), 32'd256);
        checkOutput("clr_ready_low", 32'(leak), 32'd0);
        checkOutput("clr_ready_after", 32'(wrReady), 32'd1);
        doSwap("clr_swap");
        for (int a = 0; a < 8; a++) begin
            for (int c = 0; c < 32; c++) begin
                issueRead("clr_read", 3'(a), 5'(c), 3'd0, 3'd0);
            end
        end
        endRead();

        // Swap request during a clear: FRAME_END at clear cycle 10 is lost
        swapReq = 1'b1;
        tick();
        swapReq = 1'b0;
        clear   = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        frameEnd = 1'b1;
        tick();
        frameEnd = 1'b0;
        checkOutput("sdc_front", 32'(frontBank), 32'(expFront));
        checkOutput("sdc_pending", 32'(swapPending), 32'd1);
        waitNotBusy("sdc_busy_end");
        checkOutput("sdc_pending_after", 32'(swapPending), 32'd1);
        frameEnd = 1'b1;
        tick();
        frameEnd = 1'b0;
        expFront = ~expFront;
        checkOutput("sdc_front_swap", 32'(frontBank), 32'(expFront));
        checkOutput("sdc_done", 32'(swapDone), 32'd1);
        tick();

        // Reset in the middle of a clear with a swap pending
        swapReq = 1'b1;
        tick();
        swapReq = 1'b0;
        clear   = 1'b1;
        tick();
        clear = 1'b0;
        repeat (100) tick();
        checkOutput("rmc_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rmc_busy", 32'(busy), 32'd0);
        checkOutput("rmc_ready", 32'(wrReady), 32'd1);
        checkOutput("rmc_pending", 32'(swapPending), 32'd0);
        checkOutput("rmc_front", 32'(frontBank), 32'd0);
        tick();
        checkOutput("rmc_idle_stays", 32'({busy, wrReady}), 32'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_panel_framebuffer.md
# led_panel_framebuffer

Double-buffered frame memory for the 32x16 LED panel, one bit per colour (3-bit RGB). It sits directly upstream of the panel scan driver. A pixel writer fills the back bank through a valid/ready port. The scan driver reads the front bank one row-pair and column at a time and gets the upper-half and lower-half pixels together. A requested bank swap is deferred to the scan driver's frame boundary so that no frame is displayed torn.

## Interface
Parameters:
- COLUMNS, 32: pixels per row; column index width is 5.
- ROW_PAIRS, 8: scan addresses; panel height is 2*ROW_PAIRS = 16.

Ports:
- CLOCK  in  1  single system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- WR_VALID  in  1  pixel write request.
- WR_READY  out  1  write accepted when WR_VALID && WR_READY at a posedge.
- WR_X  in  5  column 0..31.
- WR_Y  in  4  row 0..15.
- WR_RGB  in  3  pixel colour {R,G,B}.
- CLEAR  in  1  pulse; zero the entire back bank.
- BUSY  out  1  high while a clear runs.
- SWAP_REQ  in  1  pulse; request front/back exchange.
- SWAP_PENDING  out  1  swap requested, not yet executed.
- FRAME_END  in  1  pulse from scan driver after latching the last scan address.
- SWAP_DONE  out  1  one-cycle pulse on the cycle the swap takes effect.
- FRONT_BANK  out  1  bank currently displayed.
- RD_EN  in  1  read request.
- RD_ADDRESS  in  3  scan address (row pair).
- RD_COLUMN  in  5  column.
- RD_RGB_0  out  3  pixel at row RD_ADDRESS.
- RD_RGB_1  out  3  pixel at row RD_ADDRESS+8.
- RD_VALID  out  1  RD_RGB_* valid.

## Operation
- Storage: two arrays (upper half, lower half). Each array is 2 banks x 8 x 32 x 3 bits. Array index is {bank, row[2:0], col[4:0]}. WR_Y[3] selects the array.
- Memory contents are not affected by RESET.
- Reset values: FRONT_BANK=0, WR_READY=1, BUSY=0, SWAP_PENDING=0, SWAP_DONE=0, RD_VALID=0, RD_RGB_0=RD_RGB_1=0, clear counter=0.
- State machine, IDLE:
  - WR_READY=1.
  - An accepted write stores WR_RGB at {~FRONT_BANK, WR_Y[2:0], WR_X} in the array chosen by WR_Y[3].
  - CLEAR=1 moves to CLEARING. A write in the same cycle as CLEAR is still accepted, and the clear then overwrites it.
- State machine, CLEARING:
  - WR_READY=0, BUSY=1.
  - Each cycle, writes 0 to both arrays at {~FRONT_BANK, cnt[7:0]}, with cnt counting 0..255.
  - When cnt=255 is written, returns to IDLE. The clear therefore takes exactly 256 cycles.
  - CLEAR pulses during CLEARING are ignored.
- Swap:
  - SWAP_REQ sets SWAP_PENDING. Repeated requests while pending are merged into one.
  - The swap executes on a posedge where SWAP_PENDING=1, FRAME_END=1 and the state is not CLEARING.
  - On execution: FRONT_BANK toggles, SWAP_PENDING clears and SWAP_DONE pulses on the following cycle.
  - FRAME_END with no pending swap does nothing.
  - If SWAP_REQ and FRAME_END arrive in the same cycle, the swap waits for the next FRAME_END.
  - A FRAME_END that arrives during CLEARING is lost for swap purposes; the next FRAME_END after the clear completes executes the swap.
- Write coinciding with swap: the bank is selected by FRONT_BANK before the edge. The write therefore lands in the outgoing back bank, which becomes the front bank.
- Read path:
  - RD_EN samples RD_ADDRESS, RD_COLUMN and the current FRONT_BANK.
  - Next cycle: RD_RGB_0 = upper[{bank,addr,col}], RD_RGB_1 = lower[{bank,addr,col}], RD_VALID=1.
  - Without RD_EN: RD_VALID=0 and RD_RGB_* hold their last values.
- Reads and writes never address the same bank simultaneously, so there is no read/write collision.

## Timing
- Write acceptance to storage: same posedge. Data becomes visible to reads only after a swap.
- Read latency: 1 cycle. Back-to-back reads run at full rate, one per cycle.
- Swap: FRAME_END edge changes FRONT_BANK; SWAP_DONE is high during the next cycle. A read issued in the same cycle as FRAME_END uses the old bank.
- RESET mid-clear: next cycle state is IDLE, BUSY=0, WR_READY=1, pending swap discarded, FRONT_BANK=0. The partially cleared memory stays as is.
- Coordinates are not range-checked; every 5/4-bit value maps to a valid location.

## Test plan
- Reset: assert RESET 2 cycles -> FRONT_BANK=0, WR_READY=1, BUSY=0, SWAP_PENDING=0, RD_VALID=0, RD_RGB_*=0.
- Write/swap/read: write (x=5,y=3,rgb=5) and (x=5,y=11,rgb=2), pulse SWAP_REQ, pulse FRAME_END, then read addr=3 col=5 -> SWAP_DONE pulse, FRONT_BANK=1, one cycle after RD_EN: RD_VALID=1, RD_RGB_0=5, RD_RGB_1=2.
- Deferred swap: SWAP_REQ, then 100 cycles without FRAME_END -> SWAP_PENDING=1, FRONT_BANK unchanged, reads return old contents.
- Clear: fill back bank with 7, pulse CLEAR -> WR_READY=0 and BUSY=1 for exactly 256 cycles, a WR_VALID held during that time is not accepted. Then swap and read all 8x32 -> every RGB_0 and RGB_1 = 0.
- Swap during clear: SWAP_REQ, then CLEAR, then FRAME_END at clear cycle 10 -> no swap. The next FRAME_END after BUSY falls -> swap.
- Reset mid-clear at cycle 100 -> BUSY=0 next cycle, WR_READY=1, SWAP_PENDING=0.
